// File: rtl/alu_share_scheduler_if.sv
// Requester, ALU and response signals of the shared-ALU scheduler.
// The scheduler connects through the slave modport; the requester/ALU side uses master.
interface alu_share_scheduler_if #(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned OP_WIDTH = 4,
   parameter int unsigned ID_WIDTH = 2
);
   logic [NUM_REQ-1:0]          req_valid;
   logic [NUM_REQ-1:0]          req_ready;
   logic [NUM_REQ*WIDTH-1:0]    req_a;
   logic [NUM_REQ*WIDTH-1:0]    req_b;
   logic [NUM_REQ*OP_WIDTH-1:0] req_op;
   logic [WIDTH-1:0]            alu_a;
   logic [WIDTH-1:0]            alu_b;
   logic [OP_WIDTH-1:0]         alu_op;
   logic [WIDTH-1:0]            alu_result;
   logic                        rsp_valid;
   logic                        rsp_ready;
   logic [WIDTH-1:0]            rsp_data;
   logic [ID_WIDTH-1:0]         rsp_id;
   logic                        busy;
   logic [15:0]                 ops_done;

   modport slave (
      input  req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
      output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_id, busy, ops_done
   );

   modport master (
      output req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
      input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_id, busy, ops_done
   );
endinterface

// File: rtl/alu_share_scheduler.sv
// Round-robin scheduler sharing one combinational ALU among NUM_REQ requesters.
// Accept in IDLE, sample the ALU during one EXEC cycle, hold the result in RESP until taken.
module alu_share_scheduler #(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned OP_WIDTH = 4,
   parameter int unsigned ID_WIDTH = 2
) (
   input logic                  clk,
   input logic                  rst_n,
   alu_share_scheduler_if.slave bus
);
   localparam int unsigned SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t               state_q, state_d;
   logic [SEL_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [WIDTH-1:0]     alu_a_q, alu_a_d;
   logic [WIDTH-1:0]     alu_b_q, alu_b_d;
   logic [OP_WIDTH-1:0]  alu_op_q, alu_op_d;
   logic [WIDTH-1:0]     rsp_data_q, rsp_data_d;
   logic [ID_WIDTH-1:0]  rsp_id_q, rsp_id_d;
   logic [15:0]          ops_done_q, ops_done_d;

   logic                 gnt_found;
   logic [SEL_W-1:0]     gnt_sel;
   logic [NUM_REQ-1:0]   ready_c;

   logic [WIDTH-1:0]     req_a_arr  [NUM_REQ];
   logic [WIDTH-1:0]     req_b_arr  [NUM_REQ];
   logic [OP_WIDTH-1:0]  req_op_arr [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_a_arr[gi]  = bus.req_a[gi*WIDTH +: WIDTH];
      assign req_b_arr[gi]  = bus.req_b[gi*WIDTH +: WIDTH];
      assign req_op_arr[gi] = bus.req_op[gi*OP_WIDTH +: OP_WIDTH];
   end

   // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      int unsigned cand;
      cand      = 0;
      gnt_found = 1'b0;
      gnt_sel   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = 32'(rr_ptr_q) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!gnt_found && bus.req_valid[cand[SEL_W-1:0]]) begin
            gnt_found = 1'b1;
            gnt_sel   = cand[SEL_W-1:0];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_op_d   = alu_op_q;
      rsp_data_d = rsp_data_q;
      rsp_id_d   = rsp_id_q;
      ops_done_d = ops_done_q;
      ready_c    = '0;
      unique case (state_q)
         IDLE: begin
            if (gnt_found) begin
               ready_c[gnt_sel] = 1'b1;
               alu_a_d          = req_a_arr[gnt_sel];
               alu_b_d          = req_b_arr[gnt_sel];
               alu_op_d         = req_op_arr[gnt_sel];
               rsp_id_d         = ID_WIDTH'(gnt_sel);
               rr_ptr_d         = (gnt_sel == SEL_W'(NUM_REQ - 1)) ? '0 : gnt_sel + 1'b1;
               state_d          = EXEC;
            end
         end
         EXEC: begin
            rsp_data_d = bus.alu_result;
            state_d    = RESP;
         end
         RESP: begin
            if (bus.rsp_ready) begin
               ops_done_d = ops_done_q + 16'd1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_op_q   <= '0;
         rsp_data_q <= '0;
         rsp_id_q   <= '0;
         ops_done_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_op_q   <= alu_op_d;
         rsp_data_q <= rsp_data_d;
         rsp_id_q   <= rsp_id_d;
         ops_done_q <= ops_done_d;
      end
   end

   // Grant is combinational from IDLE, so it is masked while reset is held.
   assign bus.req_ready = ready_c & {NUM_REQ{rst_n}};
   assign bus.alu_a     = alu_a_q;
   assign bus.alu_b     = alu_b_q;
   assign bus.alu_op    = alu_op_q;
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.ops_done  = ops_done_q;
endmodule
